sap_datapath: RTL and testbench

//  Executes the 15-bit control word issued by the microcode decoder each micro-step.

---
 rtl/sap_pkg.sv | 41 ++++
 rtl/sap_ram.sv | 46 ++++
 rtl/sap_datapath.sv | 143 ++++++++++++++
 tb/tb_sap_datapath.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sap_pkg.sv
// rtl/sap_pkg.sv - shared types and constants for the SAP datapath and decoder
// Purpose: control-word layout shared with the microcode decoder, opcode
//          encodings and default widths.
// Ports:   none (package).
package sap_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 4;

  // Bit order matches the decoder's 15-bit control word, hlt is the MSB.
  typedef struct packed {
    logic hlt;
    logic mi;
    logic ri;
    logic ro;
    logic io;
    logic ii;
    logic ai;
    logic ao;
    logic sumo;
    logic sub;
    logic bi;
    logic oi;
    logic ce;
    logic co;
    logic j;
  } ctrl_word_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'he;
  localparam logic [3:0] OP_HLT = 4'hf;

endpackage

// File: rtl/sap_ram.sv
// rtl/sap_ram.sv - 2**ADDR_W x DATA_W RAM with run/program write ports
// Purpose: program/data store. prog_mode selects which write port owns the
//          single write path; read is asynchronous.
// Ports:   clk; prog_mode; run_we/run_addr/run_data (datapath ri);
//          prog_we/prog_addr/prog_data (loader); rd_addr -> rd_data.
module sap_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              prog_mode,
  input  logic              run_we,
  input  logic [ADDR_W-1:0] run_addr,
  input  logic [DATA_W-1:0] run_data,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  logic              we_sel;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] data_sel;

  always_comb begin
    we_sel   = run_we;
    addr_sel = run_addr;
    data_sel = run_data;
    if (prog_mode) begin
      we_sel   = prog_we;
      addr_sel = prog_addr;
      data_sel = prog_data;
    end
  end

  // No reset: contents must survive rst.
  always_ff @(posedge clk) begin
    if (we_sel) mem[addr_sel] <= data_sel;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sap_datapath.sv
// rtl/sap_datapath.sv - SAP shared bus, registers, ALU, flags and RAM
// Purpose: executes one 15-bit control word per posedge.
// Ports:   clk, rst (async, active-low); control lines hlt..j;
//          prog_mode/prog_we/prog_addr/prog_data RAM loader;
//          insn, cf, zf to decoder; out_val/out_valid display;
//          bus, pc debug; bus_conflict sticky multi-driver flag.
module sap_datapath
  import sap_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hlt, mi, ri, ro,
  input  logic              io, ii, ai, ao,
  input  logic              sumo, sub, bi,
  input  logic              oi, ce, co, j,
  input  logic              prog_mode,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [DATA_W-1:0] insn,
  output logic              cf,
  output logic              zf,
  output logic [DATA_W-1:0] out_val,
  output logic              out_valid,
  output logic [DATA_W-1:0] bus,
  output logic [ADDR_W-1:0] pc,
  output logic              bus_conflict
);

  ctrl_word_t cw;
  assign cw = {hlt, mi, ri, ro, io, ii, ai, ao, sumo, sub, bi, oi, ce, co, j};

  logic [ADDR_W-1:0] pc_q, pc_d, mar_q, mar_d;
  logic [DATA_W-1:0] ir_q, ir_d, a_q, a_d, b_q, b_d, out_q, out_d;
  logic              cf_q, cf_d, zf_q, zf_d, out_valid_q, out_valid_d;
  logic              bus_conflict_q, bus_conflict_d;

  logic [DATA_W-1:0] ram_rd;
  logic [DATA_W-1:0] b_op;
  logic [DATA_W:0]   sum_full;
  logic [2:0]        n_drv;
  logic              run;

  // Registers only move in run mode and when not halted.
  assign run = !prog_mode && !cw.hlt;

  // Subtract is A + ~B + 1; the ninth bit is the carry flag.
  assign b_op     = cw.sub ? ~b_q : b_q;
  assign sum_full = {1'b0, a_q} + {1'b0, b_op} + {{DATA_W{1'b0}}, cw.sub};

  assign n_drv = {2'b0, cw.ro} + {2'b0, cw.io} + {2'b0, cw.ao}
               + {2'b0, cw.sumo} + {2'b0, cw.co};

  always_comb begin
    bus = '0;
    if (cw.ro)        bus = ram_rd;
    else if (cw.io)   bus = {{(DATA_W-4){1'b0}}, ir_q[3:0]};
    else if (cw.ao)   bus = a_q;
    else if (cw.sumo) bus = sum_full[DATA_W-1:0];
    else if (cw.co)   bus = {{(DATA_W-ADDR_W){1'b0}}, pc_q};
  end

  sap_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk      (clk),
    .prog_mode(prog_mode),
    .run_we   (run && cw.ri),
    .run_addr (mar_q),
    .run_data (bus),
    .prog_we  (prog_we),
    .prog_addr(prog_addr),
    .prog_data(prog_data),
    .rd_addr  (mar_q),
    .rd_data  (ram_rd)
  );

  always_comb begin
    pc_d           = pc_q;
    mar_d          = mar_q;
    ir_d           = ir_q;
    a_d            = a_q;
    b_d            = b_q;
    out_d          = out_q;
    cf_d           = cf_q;
    zf_d           = zf_q;
    out_valid_d    = 1'b0;
    // Control lines are ignored while loading, so no conflict can arise then.
    bus_conflict_d = bus_conflict_q | (!prog_mode && (n_drv > 3'd1));
    if (run) begin
      if (cw.mi) mar_d = bus[ADDR_W-1:0];
      if (cw.ii) ir_d  = bus;
      if (cw.ai) a_d   = bus;
      if (cw.bi) b_d   = bus;
      if (cw.oi) begin
        out_d       = bus;
        out_valid_d = 1'b1;
      end
      if (cw.sumo) begin
        cf_d = sum_full[DATA_W];
        zf_d = (sum_full[DATA_W-1:0] == '0);
      end
      if (cw.j)       pc_d = bus[ADDR_W-1:0];
      else if (cw.ce) pc_d = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q           <= '0;
      mar_q          <= '0;
      ir_q           <= '0;
      a_q            <= '0;
      b_q            <= '0;
      out_q          <= '0;
      cf_q           <= 1'b0;
      zf_q           <= 1'b0;
      out_valid_q    <= 1'b0;
      bus_conflict_q <= 1'b0;
    end else begin
      pc_q           <= pc_d;
      mar_q          <= mar_d;
      ir_q           <= ir_d;
      a_q            <= a_d;
      b_q            <= b_d;
      out_q          <= out_d;
      cf_q           <= cf_d;
      zf_q           <= zf_d;
      out_valid_q    <= out_valid_d;
      bus_conflict_q <= bus_conflict_d;
    end
  end

  assign insn         = ir_q;
  assign cf           = cf_q;
  assign zf           = zf_q;
  assign out_val      = out_q;
  assign out_valid    = out_valid_q;
  assign pc           = pc_q;
  assign bus_conflict = bus_conflict_q;

endmodule

// File: tb/tb_sap_datapath.sv
// tb/tb_sap_datapath.sv - self-checking bench for sap_datapath
module tb_sap_datapath;
  import sap_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       hlt, mi, ri, ro, io, ii, ai, ao, sumo, sub, bi, oi, ce, co, j;
  logic       prog_mode, prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic [7:0] insn, out_val, bus;
  logic       cf, zf, out_valid, bus_conflict;
  logic [3:0] pc;

  localparam logic [14:0] M_HLT = 15'h4000, M_MI = 15'h2000, M_RI = 15'h1000;
  localparam logic [14:0] M_RO = 15'h0800, M_IO = 15'h0400, M_II = 15'h0200;
  localparam logic [14:0] M_AI = 15'h0100, M_AO = 15'h0080, M_SUMO = 15'h0040;
  localparam logic [14:0] M_SUB = 15'h0020, M_BI = 15'h0010, M_OI = 15'h0008;
  localparam logic [14:0] M_CE = 15'h0004, M_CO = 15'h0002, M_J = 15'h0001;
  localparam logic [14:0] M_DRV = M_RO | M_IO | M_AO | M_SUMO | M_CO;

  sap_datapath dut (
    .clk(clk), .rst(rst),
    .hlt(hlt), .mi(mi), .ri(ri), .ro(ro), .io(io), .ii(ii), .ai(ai), .ao(ao),
    .sumo(sumo), .sub(sub), .bi(bi), .oi(oi), .ce(ce), .co(co), .j(j),
    .prog_mode(prog_mode), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .insn(insn), .cf(cf), .zf(zf), .out_val(out_val),
    .out_valid(out_valid), .bus(bus), .pc(pc), .bus_conflict(bus_conflict)
  );

  always #5 clk = ~clk;

  // Reference model state (plain integers).
  int m_pc, m_mar, m_ir, m_a, m_b, m_out, m_cf, m_zf, m_ov, m_conf;
  int m_mem [16];
  int n_pass = 0;
  int n_total = 0;
  logic [7:0] last_bus;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".insn"}, 32'(insn), 32'(m_ir));
    chk({tag, ".pc"}, 32'(pc), 32'(m_pc));
    chk({tag, ".cf"}, 32'(cf), 32'(m_cf));
    chk({tag, ".zf"}, 32'(zf), 32'(m_zf));
    chk({tag, ".out_val"}, 32'(out_val), 32'(m_out));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_ov));
    chk({tag, ".conflict"}, 32'(bus_conflict), 32'(m_conf));
  endtask

  task automatic set_ctrl(input logic [14:0] mask);
    {hlt, mi, ri, ro, io, ii, ai, ao, sumo, sub, bi, oi, ce, co, j} = mask;
  endtask

  // One micro-step: drive control word, predict bus and next state, clock, compare.
  task automatic step(input string tag, input logic [14:0] mask);
    ctrl_word_t c;
    int nd, sum, bval, mar_old;
    c = ctrl_word_t'(mask);
    set_ctrl(mask);
    @(negedge clk);
    nd  = int'(c.ro) + int'(c.io) + int'(c.ao) + int'(c.sumo) + int'(c.co);
    sum = c.sub ? m_a + (255 - m_b) + 1 : m_a + m_b;
    if (c.ro)        bval = m_mem[m_mar];
    else if (c.io)   bval = m_ir % 16;
    else if (c.ao)   bval = m_a;
    else if (c.sumo) bval = sum % 256;
    else if (c.co)   bval = m_pc;
    else             bval = 0;
    last_bus = bus;
    chk({tag, ".bus"}, 32'(bus), 32'(bval));
    mar_old = m_mar;
    m_ov = 0;
    if (!c.hlt) begin
      if (c.ri) m_mem[mar_old] = bval;
      if (c.mi) m_mar = bval % 16;
      if (c.ii) m_ir = bval;
      if (c.ai) m_a = bval;
      if (c.bi) m_b = bval;
      if (c.oi) begin m_out = bval; m_ov = 1; end
      if (c.sumo) begin m_cf = (sum > 255); m_zf = ((sum % 256) == 0); end
      if (c.j)       m_pc = bval % 16;
      else if (c.ce) m_pc = (m_pc + 1) % 16;
    end
    if (nd > 1) m_conf = 1;
    @(posedge clk); #1;
    check_outputs(tag);
  endtask

  // RAM load with random garbage on the (ignored) control lines.
  task automatic prog_write(input int addr, input int data);
    set_ctrl(15'($urandom));
    prog_mode = 1'b1; prog_we = 1'b1;
    prog_addr = 4'(addr); prog_data = 8'(data);
    @(posedge clk); #1;
    m_mem[addr] = data;
    m_ov = 0;
    prog_mode = 1'b0; prog_we = 1'b0;
    set_ctrl('0);
    check_outputs("prog");
  endtask

  task automatic load_a(input int v);
    prog_write(m_mar, v); step("load_a", M_RO | M_AI);
  endtask
  task automatic load_b(input int v);
    prog_write(m_mar, v); step("load_b", M_RO | M_BI);
  endtask
  task automatic set_pc(input int v);
    prog_write(m_mar, v); step("set_pc", M_RO | M_J);
  endtask

  task automatic do_reset();
    set_ctrl('0);
    rst = 1'b0;
    #2;
    m_pc = 0; m_mar = 0; m_ir = 0; m_a = 0; m_b = 0; m_out = 0;
    m_cf = 0; m_zf = 0; m_ov = 0; m_conf = 0;
    chk("reset.bus", 32'(bus), 32'h0);
    check_outputs("reset");
    #1 rst = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [14:0] mask;
    int k, saved;
    set_ctrl('0);
    prog_mode = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    rst = 1'b0;
    m_mem = '{default: 0};
    #12;
    do_reset();
    for (int i = 0; i < 16; i++) prog_write(i, int'($urandom_range(0, 255)));

    // Randomized control words against the model.
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        prog_write(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)));
      end else begin
        mask = 15'($urandom);
        if ($urandom_range(0, 3) != 0) mask &= ~M_HLT;
        if ($urandom_range(0, 3) != 0) begin
          mask &= ~M_DRV;
          k = int'($urandom_range(0, 5));
          case (k)
            0: mask |= M_RO;
            1: mask |= M_IO;
            2: mask |= M_AO;
            3: mask |= M_SUMO;
            4: mask |= M_CO;
            default: ;
          endcase
        end
        step("rand", mask);
      end
    end

    // Reset from random state; RAM must survive.
    saved = m_mem[0];
    do_reset();
    step("rst_mar", M_CO | M_MI);
    step("rst_ram", M_RO);
    chk("reset.ram_kept", 32'(last_bus), 32'(saved));

    // Load program and LDA sequence.
    prog_write(14, 8'h1C);
    prog_write(0, 8'h1E);
    step("lda1", M_CO | M_MI);
    step("lda2", M_RO | M_II | M_CE);
    step("lda3", M_IO | M_MI);
    step("lda4", M_RO | M_AI);
    chk("lda.ir", 32'(insn), 32'h1E);
    chk("lda.pc", 32'(pc), 32'h1);
    step("lda_peek", M_AO);
    chk("lda.a", 32'(last_bus), 32'h1C);

    // ADD with carry and zero.
    load_a(8'hFF); load_b(8'h01);
    step("add", M_SUMO | M_AI);
    chk("add.cf", 32'(cf), 32'h1);
    chk("add.zf", 32'(zf), 32'h1);
    step("add_peek", M_AO);
    chk("add.a", 32'(last_bus), 32'h00);

    // SUB with borrow.
    load_a(8'h05); load_b(8'h07);
    step("sub", M_SUB | M_SUMO | M_AI);
    chk("sub.cf", 32'(cf), 32'h0);
    chk("sub.zf", 32'(zf), 32'h0);
    step("sub_peek", M_AO);
    chk("sub.a", 32'(last_bus), 32'hFE);

    // PC wrap, then jump beats count.
    set_pc(8'h0F);
    step("wrap", M_CE);
    chk("wrap.pc", 32'(pc), 32'h0);
    prog_write(m_mar, 8'h6A);
    step("ld_ir", M_RO | M_II);
    step("jmp", M_IO | M_J | M_CE);
    chk("jmp.pc", 32'(pc), 32'hA);

    // OUT pulse, then halt freezes A and PC.
    load_a(8'h2A);
    step("out", M_AO | M_OI);
    chk("out.val", 32'(out_val), 32'h2A);
    chk("out.valid", 32'(out_valid), 32'h1);
    step("out_idle", '0);
    chk("out.valid_drop", 32'(out_valid), 32'h0);
    step("hlt", M_HLT | M_AI | M_CE);
    chk("hlt.pc", 32'(pc), 32'hA);
    step("hlt_peek", M_AO);
    chk("hlt.a", 32'(last_bus), 32'h2A);

    // Bus conflict: RAM wins and the flag sticks until reset.
    saved = m_mem[m_mar];
    step("conf", M_RO | M_AO);
    chk("conf.bus", 32'(last_bus), 32'(saved));
    chk("conf.flag", 32'(bus_conflict), 32'h1);
    step("conf_hold1", M_CO);
    step("conf_hold2", '0);
    chk("conf.sticky", 32'(bus_conflict), 32'h1);
    do_reset();
    chk("conf.cleared", 32'(bus_conflict), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
